display_controller: RTL and testbench

DISPLAY_CONTROLLER -- requirements
Module: display_controller

---
 rtl/display_pkg.sv | 26 ++
 rtl/display_controller_bin2bcd_seq.sv | 54 +++++
 rtl/display_controller.sv | 128 ++++++++++++
 tb/tb_display_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared glyph constants, FSM state encoding and BCD helper for the display controller.
package display_pkg;

  typedef enum logic [1:0] {StIdle, StConvert, StLoad} state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SegHex [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
  function automatic logic [19:0] bcd_adjust(input logic [19:0] bcd);
    logic [19:0] res;
    res = bcd;
    for (int i = 0; i < 5; i++) begin
      if (res[4*i +: 4] >= 4'd5) res[4*i +: 4] = res[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/display_controller_bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (double-dabble), one bit per cycle.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic [19:0] bcd_adj;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  assign bcd_adj = bcd_adjust(bcd_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        // The accumulator starts at zero, so the first iteration is a plain shift.
        bcd_q  <= {19'd0, bin[15]};
        bin_q  <= {bin[14:0], 1'b0};
        cnt_q  <= 4'd1;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        bcd_q <= {bcd_adj[18:0], bin_q[15]};
        bin_q <= {bin_q[14:0], 1'b0};
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/display_controller.sv
// Four-digit multiplexed seven-segment driver showing a 16-bit value in hex or decimal.
module display_controller
  import display_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        display_is_hex,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CntW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [15:0]      value_q;
  logic             mode_q;
  logic [3:0][3:0]  digit_q, digit_d;
  logic [3:0]       blank_q, blank_d;
  logic             dash_q, dash_d;
  logic             change, capture, start, load;
  logic             conv_busy, conv_done;
  logic [19:0]      bcd;
  logic [CntW-1:0]  cnt_q;
  logic [1:0]       idx_q;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  assign change = (value != value_q) || (display_is_hex != mode_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (change) state_d = display_is_hex ? StLoad : StConvert;
      StConvert: if (conv_done) state_d = StLoad;
      StLoad:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    capture = (state_q == StIdle) && change;
    start   = capture && !display_is_hex;
    load    = (state_q == StLoad);
  end

  // Converter samples the same input word that lands in value_q on this edge.
  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    digit_d = '0;
    blank_d = '0;
    dash_d  = 1'b0;
    if (mode_q) begin
      digit_d = value_q;
    end else if (value_q > 16'd9999) begin
      dash_d = 1'b1;
    end else begin
      digit_d    = bcd[15:0];
      blank_d[3] = (bcd[15:12] == 4'd0);
      blank_d[2] = blank_d[3] && (bcd[11:8] == 4'd0);
      blank_d[1] = blank_d[2] && (bcd[7:4] == 4'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      mode_q  <= 1'b1;
      digit_q <= '0;
      blank_q <= '0;
      dash_q  <= 1'b0;
    end else begin
      if (capture) begin
        value_q <= value;
        mode_q  <= display_is_hex;
      end
      if (load) begin
        digit_q <= digit_d;
        blank_q <= blank_d;
        dash_q  <= dash_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= 4'b1111;
      seg_q <= SegBlank;
      dp_q  <= 1'b1;
    end else begin
      if (cnt_q == CntW'(DIGIT_CYCLES - 1)) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= dash_q          ? SegDash  :
               blank_q[idx_q]  ? SegBlank : SegHex[digit_q[idx_q]];
      dp_q  <= !((idx_q == 2'd0) && !mode_q);
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_display_controller.sv
// Self-checking bench for display_controller with a short scan slot.
module tb_display_controller;

  localparam int unsigned DC = 4;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000, GA = 7'b0001000, GD = 7'b0100001;
  localparam logic [6:0] GE = 7'b0000110, GF = 7'b0001110;
  localparam logic [6:0] GBL = 7'b1111111, GDS = 7'b0111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0000;
  logic        display_is_hex = 1'b1;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  display_controller #(.DIGIT_CYCLES(DC)) dut (
    .clk            (clk),
    .reset          (reset),
    .value          (value),
    .display_is_hex (display_is_hex),
    .an             (an),
    .seg            (seg),
    .dp             (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     value;
    logic            hex;
    logic [3:0][6:0] g;    // expected glyphs, g[0] = rightmost digit
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: {an,seg,dp} got %b required %b", name, act, req);
    end
  endtask

  task automatic push_display(input logic [3:0][6:0] g, input logic hex);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      e.an  = 4'b1111;
      e.an[d] = 1'b0;
      e.seg = g[d];
      e.dp  = (d == 0 && !hex) ? 1'b0 : 1'b1;
      sb.push_back(e);
    end
  endtask

  // Align to the first cycle of digit 0, then pop one record per digit and check its 4 cycles.
  task automatic observe(input string name);
    logic [3:0] prev;
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    prev = an;
    @(negedge clk);
    while (!(an == 4'b1110 && prev != 4'b1110) && n < 40) begin
      prev = an;
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s scan: digit 0 start not seen in 40 cycles, an=%b", name, an);
      sb.delete();
    end else begin
      for (int d = 0; d < 4; d++) begin
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
          check($sformatf("%s digit%0d cyc%0d", name, d, k), {an, seg, dp}, {e.an, e.seg, e.dp});
          @(negedge clk);
        end
      end
    end
  endtask

  // Drive a vector, check the digit on screen right at the latency bound, then a full sweep.
  task automatic apply(input vec_t v, input string name);
    int idx;
    logic [3:0] exp_an;
    @(negedge clk);
    value = v.value;
    display_is_hex = v.hex;
    repeat (v.hex ? 3 : 19) @(posedge clk);
    @(negedge clk);
    case (an)
      4'b1110: idx = 0;
      4'b1101: idx = 1;
      4'b1011: idx = 2;
      4'b0111: idx = 3;
      default: idx = -1;
    endcase
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL %s latency: an=%b is not one-hot-low", name, an);
    end else begin
      exp_an = 4'b1111;
      exp_an[idx] = 1'b0;
      check($sformatf("%s latency", name), {an, seg, dp},
            {exp_an, v.g[idx], (idx == 0 && !v.hex) ? 1'b0 : 1'b1});
    end
    push_display(v.g, v.hex);
    observe(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'hDEAD, 1'b1, {GD, GE, GA, GD}};
    vecs[1] = '{16'h04D2, 1'b0, {G1, G2, G3, G4}};
    vecs[2] = '{16'h0007, 1'b0, {GBL, GBL, GBL, G7}};
    vecs[3] = '{16'h270F, 1'b0, {G9, G9, G9, G9}};
    vecs[4] = '{16'h2710, 1'b0, {GDS, GDS, GDS, GDS}};
    vecs[5] = '{16'h1234, 1'b1, {G1, G2, G3, G4}};
    vecs[6] = '{16'h0064, 1'b0, {GBL, G1, G0, G0}};
    vecs[7] = '{16'hFFFF, 1'b1, {GF, GF, GF, GF}};
    vecs[8] = '{16'h0000, 1'b0, {GBL, GBL, GBL, G0}};

    // Reset held: outputs blank.
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset hold", {an, seg, dp}, {4'b1111, GBL, 1'b1});
    @(negedge clk);
    check("reset hold2", {an, seg, dp}, {4'b1111, GBL, 1'b1});
    reset = 1'b1;

    // First slot after release: digit 0 for 4 cycles, then a full "0000" sweep.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("release cyc%0d", k), {an, seg, dp}, {4'b1110, G0, 1'b1});
    end
    push_display({G0, G0, G0, G0}, 1'b1);
    observe("post-reset");

    for (int i = 0; i < 9; i++) apply(vecs[i], $sformatf("vec%0d_%h", i, vecs[i].value));

    // Input changes mid-conversion: final display follows the last input.
    @(negedge clk);
    value = 16'h04D2;
    display_is_hex = 1'b0;
    repeat (5) @(posedge clk);
    #1 value = 16'hBEEF;
    repeat (45) @(posedge clk);
    push_display({GDS, GDS, GDS, GDS}, 1'b0);
    observe("beef");

    // Reset mid-conversion: blank immediately, then plain hex zeros.
    @(negedge clk);
    value = 16'h04D2;
    repeat (8) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("reset mid-convert", {an, seg, dp}, {4'b1111, GBL, 1'b1});
    value = 16'h0000;
    display_is_hex = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("mid-reset release", {an, seg, dp}, {4'b1110, G0, 1'b1});
    push_display({G0, G0, G0, G0}, 1'b1);
    observe("after mid-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
